frame_sync_delay_cfg: RTL and testbench
=======================================

Name: frame_sync_delay_cfg

Overview:
- Parametrised, run-time-programmable delay line for a camera-style video stream (href, vsync, pixel data) in the data_clk domain.
- Generalises the fixed 3-cycle sync/data aligner with configurable data width and maximum depth.
- Adds a delay value selectable per frame, applied only at a frame boundary, with href/data blanking while the new delay settles.
- Sits between the sensor capture interface and the downstream packer/FIFO to align video with side-channel logic of variable latency.

Parameters:
DATA_WIDTH, 8, width of source_data / source_data_delay
MAX_DELAY, 16, deepest supported delay in cycles (>=2)
DLY_W, 5, width of delay_cfg / delay_active; must satisfy 2^DLY_W > MAX_DELAY
DEFAULT_DELAY, 3, delay loaded at reset; must be in range 1..MAX_DELAY

Ports:
data_clk  input  1  pixel clock; all logic on rising edge
rst_n  input  1  synchronous reset, active-low
data_href  input  1  line valid
data_vsync  input  1  frame sync, active-high
source_data  input  DATA_WIDTH  pixel data
delay_cfg  input  DLY_W  requested delay in cycles, quasi-static; sampled only at frame boundary
data_href_delay  output  1  delayed href (blanked during switch)
data_vsync_delay  output  1  delayed vsync
source_data_delay  output  DATA_WIDTH  delayed data (zero during switch)
delay_active  output  DLY_W  delay currently applied
cfg_err  output  1  one-cycle pulse: sampled delay_cfg was out of range

Behaviour:
- Reset (rst_n=0 at a data_clk edge):
  - clears all history stages, the vsync edge register and the blank counter;
  - delay_active <= DEFAULT_DELAY; state <= RUN; cfg_err <= 0.
  - All delayed outputs read 0 until real samples propagate.
- History: MAX_DELAY-stage shift register of {vsync, href, data}. Stage 0 registers the inputs; stage k holds the input from k+1 cycles earlier.
- Output tap is stage (delay_active-1), combinational mux from registers. An input sample at edge t appears on the outputs after edge t+delay_active-1, i.e. exactly delay_active cycles of latency.
- Frame boundary = input vsync rising edge: data_vsync=1 and the registered previous vsync=0.
- At a frame boundary, in RUN:
  - cfg_ok = (delay_cfg >= 1) and (delay_cfg <= MAX_DELAY).
  - If !cfg_ok: cfg_err pulses high for 1 cycle; delay_active unchanged.
  - If cfg_ok and delay_cfg == delay_active: no action.
  - If cfg_ok and delay_cfg != delay_active: delay_active <= delay_cfg; blank_cnt <= delay_cfg + 1 (tap transient plus settle); state <= SWITCH.
- SWITCH:
  - data_href_delay forced 0 and source_data_delay forced 0; data_vsync_delay is still driven from the new tap.
  - blank_cnt decrements each cycle; when blank_cnt reaches 1, state <= RUN on the next edge.
  - Frame boundaries seen in SWITCH are ignored: no cfg sample, no cfg_err.
- RUN: outputs = tap, unmodified.
- Delay changes therefore never produce a partial line. The frame-start vsync edge may shift or repeat by up to |new-old| cycles, once per change.
- History keeps shifting in every state, including SWITCH and invalid-cfg cycles.
- Reset mid-SWITCH returns to RUN with DEFAULT_DELAY; pending state is discarded.
- Back-to-back frames: each boundary is evaluated independently once RUN is re-entered.
- delay_cfg=MAX_DELAY uses the last stage; the tap index never exceeds MAX_DELAY-1.

Test Plan:
- Reset then ramp data 0x01,0x02,... with href=1, delay_cfg=3 → source_data_delay = 0x01 on the 3rd edge after it is applied; href/vsync lag by exactly 3 cycles; delay_active=3, cfg_err never high.
- delay_cfg=7 before a vsync rising edge → delay_active=7 on the next cycle; href_delay/data forced 0 for 8 cycles; vsync_delay rises 7 cycles after the input edge; afterwards data lags input by 7.
- delay_cfg=0 and then 17 (MAX_DELAY=16) at two successive frames → cfg_err 1-cycle pulse at each boundary; delay_active stays 3; outputs undisturbed.
- delay_cfg=16 → data lags by 16. Then delay_cfg=1 next frame → lag 1, blank 2 cycles. Extra vsync edge during blank → ignored.
- Assert rst_n=0 for 1 cycle mid-SWITCH → all outputs 0 the next cycle, delay_active=3, RUN state; stream resumes with 3-cycle lag.
- DATA_WIDTH=10, MAX_DELAY=4 build: 0x3FF passes intact at delay 4; delay_cfg=5 → cfg_err pulse.

Source files
------------

// File: rtl/frame_sync_delay_cfg_if.sv
// Video stream bundle for the programmable sync/data delay line.
// The source side drives the raw stream and the requested delay; the delay
// line returns the aligned stream, the delay in force and a config error pulse.
interface frame_sync_delay_cfg_if #(
    parameter int DATA_WIDTH = 8,
    parameter int DLY_W      = 5
);
    logic                  data_href;
    logic                  data_vsync;
    logic [DATA_WIDTH-1:0] source_data;
    logic [DLY_W-1:0]      delay_cfg;

    logic                  data_href_delay;
    logic                  data_vsync_delay;
    logic [DATA_WIDTH-1:0] source_data_delay;
    logic [DLY_W-1:0]      delay_active;
    logic                  cfg_err;

    modport master (
        output data_href, data_vsync, source_data, delay_cfg,
        input  data_href_delay, data_vsync_delay, source_data_delay,
               delay_active, cfg_err
    );

    modport slave (
        input  data_href, data_vsync, source_data, delay_cfg,
        output data_href_delay, data_vsync_delay, source_data_delay,
               delay_active, cfg_err
    );
endinterface

// File: rtl/frame_sync_delay_cfg.sv
// Run-time programmable delay line for href/vsync/pixel data.
// A new delay is only taken at an input vsync rising edge; while the tap
// settles on the new depth, href and data are blanked so no partial line
// ever leaves the block. vsync keeps following the (new) tap throughout.
module frame_sync_delay_cfg #(
    parameter int DATA_WIDTH    = 8,
    parameter int MAX_DELAY     = 16,
    parameter int DLY_W         = 5,
    parameter int DEFAULT_DELAY = 3
) (
    input  logic                   data_clk,
    input  logic                   rst_n,
    frame_sync_delay_cfg_if.slave  bus
);
    // One extra bit so delay+1 cannot wrap when MAX_DELAY = 2^DLY_W - 1.
    localparam int CNT_W = DLY_W + 1;

    typedef struct packed {
        logic                  vsync;
        logic                  href;
        logic [DATA_WIDTH-1:0] data;
    } stage_t;

    typedef enum logic {RUN, SWITCH} state_t;

    stage_t [MAX_DELAY-1:0] hist;
    stage_t                 in_stage;
    stage_t                 tap;
    state_t                 state;
    logic                   vsync_q;
    logic [DLY_W-1:0]       delay_active_q;
    logic [DLY_W-1:0]       tap_idx;
    logic [CNT_W-1:0]       blank_cnt;
    logic                   cfg_err_q;
    logic                   frame_start;
    logic                   cfg_ok;

    assign in_stage    = '{vsync: bus.data_vsync, href: bus.data_href, data: bus.source_data};
    assign frame_start = bus.data_vsync & ~vsync_q;
    assign cfg_ok      = (bus.delay_cfg != '0) && (bus.delay_cfg <= DLY_W'(MAX_DELAY));
    assign tap_idx     = delay_active_q - DLY_W'(1);

    // History shifts every cycle regardless of state; stage k is k+1 cycles old.
    always_ff @(posedge data_clk) begin
        if (!rst_n) begin
            hist <= '0;
        end else begin
            hist <= {hist[MAX_DELAY-2:0], in_stage};
        end
    end

    // Delay control: sample cfg at frame start in RUN, then blank until settled.
    always_ff @(posedge data_clk) begin
        if (!rst_n) begin
            vsync_q        <= 1'b0;
            state          <= RUN;
            delay_active_q <= DLY_W'(DEFAULT_DELAY);
            blank_cnt      <= '0;
            cfg_err_q      <= 1'b0;
        end else begin
            vsync_q   <= bus.data_vsync;
            cfg_err_q <= 1'b0;
            case (state)
                RUN: begin
                    if (frame_start) begin
                        if (!cfg_ok) begin
                            cfg_err_q <= 1'b1;
                        end else if (bus.delay_cfg != delay_active_q) begin
                            delay_active_q <= bus.delay_cfg;
                            // Tap transient of 'delay' cycles plus one settle cycle.
                            blank_cnt      <= {1'b0, bus.delay_cfg} + CNT_W'(1);
                            state          <= SWITCH;
                        end
                    end
                end
                SWITCH: begin
                    // Frame starts arriving here are deliberately not sampled.
                    blank_cnt <= blank_cnt - CNT_W'(1);
                    if (blank_cnt == CNT_W'(1)) begin
                        state <= RUN;
                    end
                end
            endcase
        end
    end

    // Output tap select; a compare-per-stage mux keeps the index in range.
    always_comb begin
        tap = '0;
        for (int i = 0; i < MAX_DELAY; i++) begin
            if (tap_idx == DLY_W'(i)) begin
                tap = hist[i];
            end
        end
    end

    assign bus.data_href_delay   = (state == RUN) & tap.href;
    assign bus.source_data_delay = (state == RUN) ? tap.data : '0;
    assign bus.data_vsync_delay  = tap.vsync;
    assign bus.delay_active      = delay_active_q;
    assign bus.cfg_err           = cfg_err_q;
endmodule

// File: tb/tb_frame_sync_delay_cfg.sv
// Bench for the programmable delay line: two builds (8b/16-deep and
// 10b/4-deep) run in lockstep against a sample-history reference model.
module tb_frame_sync_delay_cfg;
    logic data_clk = 1'b0;
    logic rst_n    = 1'b0;

    always #5 data_clk = ~data_clk;

    frame_sync_delay_cfg_if #(.DATA_WIDTH(8),  .DLY_W(5)) bus0();
    frame_sync_delay_cfg_if #(.DATA_WIDTH(10), .DLY_W(3)) bus1();

    frame_sync_delay_cfg #(.DATA_WIDTH(8), .MAX_DELAY(16), .DLY_W(5), .DEFAULT_DELAY(3)) u_dut0 (
        .data_clk (data_clk),
        .rst_n    (rst_n),
        .bus      (bus0)
    );

    frame_sync_delay_cfg #(.DATA_WIDTH(10), .MAX_DELAY(4), .DLY_W(3), .DEFAULT_DELAY(3)) u_dut1 (
        .data_clk (data_clk),
        .rst_n    (rst_n),
        .bus      (bus1)
    );

    int checks = 0;
    int errors = 0;

    // Stimulus shared by both builds (cfg differs, data is truncated for dut0).
    bit         vs, hr;
    logic [9:0] d;
    int         ramp;
    int         cfg0, cfg1;

    // Reference model: every sample since reset, current delay, end of blanking.
    int         m_n    [2];
    int         m_dly  [2];
    int         m_bend [2];
    bit         m_prev [2];
    bit         m_err  [2];
    logic [11:0] m_smp [2][4096];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    function automatic int maxd(input int k);
        return (k == 0) ? 16 : 4;
    endfunction

    task automatic apply();
        bus0.data_vsync  = vs;
        bus0.data_href   = hr;
        bus0.source_data = d[7:0];
        bus0.delay_cfg   = cfg0[4:0];
        bus1.data_vsync  = vs;
        bus1.data_href   = hr;
        bus1.source_data = d;
        bus1.delay_cfg   = cfg1[2:0];
    endtask

    task automatic model_edge(input int k);
        int          cfg;
        logic [11:0] s;
        bit          in_sw, fs;
        cfg = (k == 0) ? (cfg0 & 31) : (cfg1 & 7);
        s   = {vs, hr, (k == 0) ? {2'b00, d[7:0]} : d};
        if (!rst_n) begin
            m_n[k] = 0; m_dly[k] = 3; m_bend[k] = 0; m_prev[k] = 0; m_err[k] = 0;
        end else begin
            in_sw    = m_n[k] < m_bend[k];
            fs       = vs && !m_prev[k];
            m_err[k] = 0;
            m_smp[k][m_n[k] % 4096] = s;
            m_n[k]++;
            if (fs && !in_sw) begin
                if (cfg < 1 || cfg > maxd(k)) begin
                    m_err[k] = 1;
                end else if (cfg != m_dly[k]) begin
                    m_dly[k]  = cfg;
                    m_bend[k] = m_n[k] + cfg + 1;
                end
            end
            m_prev[k] = vs;
        end
    endtask

    task automatic check_out(input int k);
        logic [11:0] s;
        bit          bl;
        logic [31:0] eh, ev, ed;
        s  = (m_n[k] >= m_dly[k]) ? m_smp[k][(m_n[k] - m_dly[k]) % 4096] : 12'h0;
        bl = m_n[k] < m_bend[k];
        eh = bl ? 32'd0 : 32'(s[10]);
        ev = 32'(s[11]);
        ed = bl ? 32'd0 : 32'(s[9:0]);
        if (k == 0) begin
            chk("href0",  32'(bus0.data_href_delay),   eh);
            chk("vsync0", 32'(bus0.data_vsync_delay),  ev);
            chk("data0",  32'(bus0.source_data_delay), ed);
            chk("dly0",   32'(bus0.delay_active),      32'(m_dly[0]));
            chk("err0",   32'(bus0.cfg_err),           32'(m_err[0]));
        end else begin
            chk("href1",  32'(bus1.data_href_delay),   eh);
            chk("vsync1", 32'(bus1.data_vsync_delay),  ev);
            chk("data1",  32'(bus1.source_data_delay), ed);
            chk("dly1",   32'(bus1.delay_active),      32'(m_dly[1]));
            chk("err1",   32'(bus1.cfg_err),           32'(m_err[1]));
        end
    endtask

    // One clock: drive, model the edge, then sample 1 time unit later.
    task automatic step();
        apply();
        @(posedge data_clk);
        model_edge(0);
        model_edge(1);
        #1;
        check_out(0);
        check_out(1);
        ramp++;
        d = (ramp % 7 == 0) ? 10'h3FF : 10'(ramp);
    endtask

    task automatic frame(input int c0, input int c1, input int len);
        cfg0 = c0; cfg1 = c1;
        vs = 1'b1; hr = 1'b0;
        repeat (3) step();
        vs = 1'b0;
        repeat (2) step();
        hr = 1'b1;
        repeat (len) step();
        hr = 1'b0;
        repeat (4) step();
    endtask

    initial begin
        vs = 1'b0; hr = 1'b0; ramp = 1; d = 10'h001; cfg0 = 3; cfg1 = 3;
        rst_n = 1'b0;
        repeat (2) step();
        rst_n = 1'b1;

        // Steady stream at the default delay.
        hr = 1'b1;
        repeat (12) step();
        hr = 1'b0;
        repeat (2) step();

        // Delay change, then two rejected configs, then deepest / shallowest.
        frame(7, 2, 12);
        frame(0, 0, 6);
        frame(17, 5, 6);
        frame(16, 4, 24);

        // Switch to delay 1 with a second vsync edge inside the blank window.
        cfg0 = 1; cfg1 = 1; vs = 1'b1;
        step();
        vs = 1'b0; cfg0 = 5; cfg1 = 2;
        step();
        vs = 1'b1;
        step();
        vs = 1'b0;
        step();
        hr = 1'b1;
        repeat (8) step();
        hr = 1'b0;
        repeat (2) step();

        // Reset in the middle of a long switch.
        cfg0 = 10; cfg1 = 2; vs = 1'b1;
        step();
        vs = 1'b0;
        repeat (3) step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1; hr = 1'b1;
        repeat (10) step();
        hr = 1'b0;
        step();

        // Randomized frames, configs and occasional resets.
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 9) == 0) vs = ~vs;
            hr = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 39) == 0) begin
                cfg0 = int'($urandom_range(0, 18));
                cfg1 = int'($urandom_range(0, 7));
            end
            rst_n = ($urandom_range(0, 599) != 0);
            step();
        end
        rst_n = 1'b1;
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
